div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the DIV/DIVU instructions. It sits directly downstream of the register file: it consumes the two read ports (rs as dividend, rt as divisor) and produces quotient and remainder for the HI/LO registers. Division is restoring, one quotient bit per cycle, in signed or unsigned mode. A start/busy/done handshake lets the controller stall the pipeline while a division is in flight.

---
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign correction and divide-by-zero handling applied in a final FIX cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic             accept;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rem_reg, quo_reg, dmag_reg, dvd_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_step, quo_step;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count_reg == CW'(WIDTH - 1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Negating 0x80..0 yields 0x80..0, which is the correct magnitude when read unsigned.
  always_comb begin
    mag_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // Remainder stays below the divisor magnitude, so the shifted value needs one extra bit.
  always_comb begin
    shifted   = {rem_reg, quo_reg[WIDTH-1]};
    diff      = shifted - {1'b0, dmag_reg};
    no_borrow = ~diff[WIDTH];
    rem_step  = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step  = {quo_reg[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dmag_reg  <= '0;
      dvd_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        quo_reg   <= mag_a;
        dmag_reg  <= mag_b;
        dvd_reg   <= dividend;
        rem_reg   <= '0;
        count_reg <= '0;
        neg_q_reg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r_reg <= is_signed & dividend[WIDTH-1];
      end else if (state_reg == CALC) begin
        rem_reg   <= rem_step;
        quo_reg   <= quo_step;
        count_reg <= count_reg + CW'(1);
      end else if (state_reg == FIX) begin
        if (dmag_reg == '0) begin
          lo_reg <= '1;
          hi_reg <= dvd_reg;
        end else begin
          lo_reg <= neg_q_reg ? -quo_reg : quo_reg;
          hi_reg <= neg_r_reg ? -rem_reg : rem_reg;
        end
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed cases plus randomized operands
// against an arithmetic reference, with latency, hold and reset checks.
module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, start, is_signed;
  logic [W-1:0] dividend, divisor;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cap_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  logic [W-1:0] hold_hi = '0, hold_lo = '0;

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: plain integer division; SV '/' and '%' truncate toward zero.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (b == 0) return {a, {W{1'b1}}};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[W-1:0], q[W-1:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Monitor: pops the scoreboard on each done pulse, checks hold and reset state otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        hold_hi = '0;
        hold_lo = '0;
        exp_q.delete();
      end else if (done) begin
        check("done_busy", {31'b0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("lo", lo, e.lo);
          check("hi", hi, e.hi);
          check("latency", 32'(cyc - e.cap_cyc), 32'(LAT));
          hold_hi = e.hi;
          hold_lo = e.lo;
        end
      end else begin
        check("hold_hi", hi, hold_hi);
        check("hold_lo", lo, hold_lo);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0 within 100 cycles");
    end
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    exp_q.push_back('{eh, el, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got done=0 expected done within 60 cycles");
    end
  endtask

  // A start with different operands while busy must have no effect.
  task automatic poke();
    repeat (5) @(negedge clk);
    start = 1'b1; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return W'($urandom_range(0, 15));
      1: return -W'($urandom_range(1, 15));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [W-1:0] d_a [9] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000};
  logic [W-1:0] d_b [9] = '{32'd7, 32'd1, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                            32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF};
  logic         d_s [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] d_hi[9] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                            32'd1, 32'h1234_5678, 32'h1234_5678, 32'd0};
  logic [W-1:0] d_lo[9] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,
                            32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};

  initial begin
    logic [W-1:0]   a, b;
    logic           s;
    logic [2*W-1:0] r;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      issue(d_a[i], d_b[i], d_s[i], d_hi[i], d_lo[i]);
      if (i == 0 || i == 4) poke();
      wait_done();
      if (i % 3 == 0) @(negedge clk);
    end

    issue(32'd1000, 32'd3, 1'b0, 32'd1, 32'd333);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'd9, 32'd3, 1'b0, 32'd0, 32'd3);
    wait_done();

    for (int i = 0; i < 2000; i++) begin
      a = pick();
      b = pick();
      s = 1'($urandom);
      r = model(a, b, s);
      issue(a, b, s, r[2*W-1:W], r[W-1:0]);
      if (i % 97 == 0) poke();
      wait_done();
      if (i % 7 == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
